// File: rtl/beam_topk_sort.sv
// rtl/beam_topk_sort.sv - parallel pairwise beam-power ranker with top-K FIFO
module beam_topk_sort #(
    parameter  int IW        = 32,
    parameter  int COL       = 64,
    parameter  int TOPK      = 16,
    parameter  int RBG_DEPTH = 16,
    localparam int IDXW      = $clog2(COL),
    localparam int CW        = $clog2(RBG_DEPTH) + 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [COL-1:0][IW-1:0]         i_data,
    input  logic                           i_valid,
    input  logic                           i_mode,
    input  logic                           i_sop,
    input  logic [7:0]                     i_rbg_max,
    output logic                           o_in_ready,
    output logic [COL-1:0][IDXW-1:0]       o_rank,
    output logic                           o_rank_valid,
    input  logic                           i_rd_en,
    output logic                           o_rd_valid,
    output logic [TOPK-1:0][IDXW-1:0]      o_beam_index,
    output logic [TOPK-1:0][IW-1:0]        o_beam_power,
    output logic [7:0]                     o_rbg_num,
    output logic [CW-1:0]                  o_count,
    output logic                           o_empty,
    output logic                           o_full,
    output logic                           o_drop,
    output logic                           o_underflow
);
    localparam int AW = CW - 1;

    logic                       s1_valid_q, s1_mode_q;
    logic [COL-1:0][IW-1:0]     s1_data_q;
    logic [7:0]                 s1_tag_q, s2_tag_q, last_tag_q, tag_d;
    logic                       first_q;
    logic [COL-1:0][IDXW-1:0]   rank_c, rank_q;
    logic                       s2_valid_q;
    logic [TOPK-1:0][IDXW-1:0]  slot_idx_c, slot_idx_q;
    logic [TOPK-1:0][IW-1:0]    slot_pow_c, slot_pow_q;
    logic [AW-1:0]              wptr_q, rptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic                       rd_valid_q, drop_q, underflow_q;
    logic [TOPK-1:0][IDXW-1:0]  out_idx_q;
    logic [TOPK-1:0][IW-1:0]    out_pow_q;
    logic [7:0]                 out_tag_q;
    logic                       accept, wr, pop, ready;

    logic [TOPK-1:0][IDXW-1:0]  mem_idx [RBG_DEPTH];
    logic [TOPK-1:0][IW-1:0]    mem_pow [RBG_DEPTH];
    logic [7:0]                 mem_tag [RBG_DEPTH];

    // Ties resolve toward the lower index, so ranks are always a permutation.
    always_comb begin
        rank_c = '0;
        for (int i = 0; i < COL; i++) begin
            for (int j = 0; j < COL; j++) begin
                if ((s1_mode_q ? (s1_data_q[j] < s1_data_q[i]) : (s1_data_q[j] > s1_data_q[i])) ||
                    ((j < i) && (s1_data_q[j] == s1_data_q[i])))
                    rank_c[i] = rank_c[i] + IDXW'(1);
            end
        end
    end

    always_comb begin
        slot_idx_c = '0;
        slot_pow_c = '0;
        for (int k = 0; k < TOPK; k++) begin
            for (int i = 0; i < COL; i++) begin
                if (rank_c[i] == IDXW'(k)) begin
                    slot_idx_c[k] = IDXW'(i);
                    slot_pow_c[k] = s1_data_q[i];
                end
            end
        end
    end

    always_comb begin
        ready   = ({1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q)) < (CW+1)'(RBG_DEPTH);
        accept  = i_valid & ready;
        wr      = s2_valid_q;
        pop     = i_rd_en & (count_q != '0);
        count_d = count_q + CW'(wr) - CW'(pop);
        if (i_sop || first_q || (last_tag_q == i_rbg_max))
            tag_d = 8'd0;
        else
            tag_d = last_tag_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_data_q   <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_tag_q    <= '0;
            rank_q      <= '0;
            slot_idx_q  <= '0;
            slot_pow_q  <= '0;
            last_tag_q  <= '0;
            first_q     <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            out_idx_q   <= '0;
            out_pow_q   <= '0;
            out_tag_q   <= '0;
            drop_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_data_q  <= i_data;
                s1_mode_q  <= i_mode;
                s1_tag_q   <= tag_d;
                last_tag_q <= tag_d;
                first_q    <= 1'b0;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rank_q     <= rank_c;
                slot_idx_q <= slot_idx_c;
                slot_pow_q <= slot_pow_c;
                s2_tag_q   <= s1_tag_q;
            end
            if (wr)
                wptr_q <= wptr_q + AW'(1);
            rd_valid_q <= pop;
            if (pop) begin
                out_idx_q <= mem_idx[rptr_q];
                out_pow_q <= mem_pow[rptr_q];
                out_tag_q <= mem_tag[rptr_q];
                rptr_q    <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            if (i_valid && !ready)
                drop_q <= 1'b1;
            if (i_rd_en && (count_q == '0))
                underflow_q <= 1'b1;
        end
    end

    // Storage array needs no reset; validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem_idx[wptr_q] <= slot_idx_q;
            mem_pow[wptr_q] <= slot_pow_q;
            mem_tag[wptr_q] <= s2_tag_q;
        end
    end

    assign o_in_ready   = ready;
    assign o_rank       = rank_q;
    assign o_rank_valid = s2_valid_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_beam_index = out_idx_q;
    assign o_beam_power = out_pow_q;
    assign o_rbg_num    = out_tag_q;
    assign o_count      = count_q;
    assign o_empty      = (count_q == '0);
    assign o_full       = (count_q == CW'(RBG_DEPTH));
    assign o_drop       = drop_q;
    assign o_underflow  = underflow_q;
endmodule

// File: tb/tb_beam_topk_sort.sv
// tb/tb_beam_topk_sort.sv - directed table-driven bench for beam_topk_sort
module tb_beam_topk_sort;
    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [7:0][7:0]      data;
    logic                 valid, mode, sop, rd_en;
    logic [7:0]           rbg_max;
    logic                 in_ready, rank_valid, rd_valid, empty, full, drop, underflow;
    logic [7:0][2:0]      rank;
    logic [3:0][2:0]      beam_index;
    logic [3:0][7:0]      beam_power;
    logic [7:0]           rbg_num;
    logic [2:0]           count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    beam_topk_sort #(.IW(8), .COL(8), .TOPK(4), .RBG_DEPTH(4)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_data(data), .i_valid(valid),
        .i_mode(mode), .i_sop(sop), .i_rbg_max(rbg_max), .o_in_ready(in_ready),
        .o_rank(rank), .o_rank_valid(rank_valid), .i_rd_en(rd_en),
        .o_rd_valid(rd_valid), .o_beam_index(beam_index), .o_beam_power(beam_power),
        .o_rbg_num(rbg_num), .o_count(count), .o_empty(empty), .o_full(full),
        .o_drop(drop), .o_underflow(underflow)
    );

    typedef struct {
        logic [7:0][7:0] d;
        logic            mode;
        logic [7:0][2:0] rank;
        logic [3:0][2:0] idx;
        logic [3:0][7:0] pow;
    } vec_t;

    vec_t tbl [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0][7:0] d, input logic m, input logic s);
        data  = d;
        mode  = m;
        sop   = s;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        sop   = 1'b0;
    endtask

    task automatic pop;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0].d    = {8'd2, 8'd3, 8'd7, 8'd0, 8'd9, 8'd1, 8'd9, 8'd5};
        tbl[0].mode = 1'b0;
        tbl[0].rank = {3'd5, 3'd4, 3'd2, 3'd7, 3'd1, 3'd6, 3'd0, 3'd3};
        tbl[0].idx  = {3'd0, 3'd5, 3'd3, 3'd1};
        tbl[0].pow  = {8'd5, 8'd7, 8'd9, 8'd9};
        tbl[1].d    = {8'd2, 8'd3, 8'd7, 8'd0, 8'd9, 8'd1, 8'd9, 8'd5};
        tbl[1].mode = 1'b1;
        tbl[1].rank = {3'd2, 3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd6, 3'd4};
        tbl[1].idx  = {3'd6, 3'd7, 3'd2, 3'd4};
        tbl[1].pow  = {8'd3, 8'd2, 8'd1, 8'd0};
        tbl[2].d    = {8{8'h55}};
        tbl[2].mode = 1'b0;
        tbl[2].rank = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        tbl[2].idx  = {3'd3, 3'd2, 3'd1, 3'd0};
        tbl[2].pow  = {4{8'h55}};
        tbl[3].d    = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[3].mode = 1'b0;
        tbl[3].rank = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        tbl[3].idx  = {3'd4, 3'd5, 3'd6, 3'd7};
        tbl[3].pow  = {8'd50, 8'd60, 8'd70, 8'd80};
        tbl[4].d    = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        tbl[4].mode = 1'b1;
        tbl[4].rank = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        tbl[4].idx  = {3'd3, 3'd2, 3'd1, 3'd0};
        tbl[4].pow  = {8'd40, 8'd30, 8'd20, 8'd10};

        reset_n = 1'b0; data = '0; valid = 1'b0; mode = 1'b0; sop = 1'b0;
        rd_en = 1'b0; rbg_max = 8'd255;
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rank_valid", 64'(rank_valid), 64'd0);
        chk("rst_flags", 64'({drop, underflow}), 64'd0);

        // Latency: rank at T+2, FIFO entry at T+3, popped data at T+4
        for (int n = 0; n < 5; n++) begin
            send(tbl[n].d, tbl[n].mode, 1'b1);
            chk("rank_valid_t1", 64'(rank_valid), 64'd0);
            tick();
            chk("rank_valid_t2", 64'(rank_valid), 64'd1);
            chk("rank", 64'(rank), 64'(tbl[n].rank));
            chk("count_t2", 64'(count), 64'd0);
            tick();
            chk("rank_valid_t3", 64'(rank_valid), 64'd0);
            chk("count_t3", 64'(count), 64'd1);
            pop();
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("beam_index", 64'(beam_index), 64'(tbl[n].idx));
            chk("beam_power", 64'(beam_power), 64'(tbl[n].pow));
            chk("rbg_num", 64'(rbg_num), 64'd0);
            chk("count_after_pop", 64'(count), 64'd0);
            chk("empty_after_pop", 64'(empty), 64'd1);
            tick();
            chk("rd_valid_pulse", 64'(rd_valid), 64'd0);
        end

        // Back-pressure: 5 back-to-back vectors, no reads
        for (int k = 0; k < 5; k++) begin
            data  = {8{8'(k + 1)}};
            mode  = 1'b0;
            sop   = (k == 0);
            valid = 1'b1;
            chk("bp_ready", 64'(in_ready), (k < 4) ? 64'd1 : 64'd0);
            chk("bp_drop_before", 64'(drop), 64'd0);
            tick();
        end
        valid = 1'b0;
        sop   = 1'b0;
        chk("bp_drop", 64'(drop), 64'd1);
        tick(); tick();
        chk("bp_full", 64'(full), 64'd1);
        chk("bp_count", 64'(count), 64'd4);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            pop();
            chk("bp_rd_valid", 64'(rd_valid), 64'd1);
            chk("bp_power", 64'(beam_power), 64'({4{8'(k + 1)}}));
            chk("bp_tag", 64'(rbg_num), 64'(k));
        end
        chk("bp_empty", 64'(empty), 64'd1);
        chk("bp_underflow_before", 64'(underflow), 64'd0);
        pop();
        chk("bp_underflow", 64'(underflow), 64'd1);
        chk("bp_underflow_rd_valid", 64'(rd_valid), 64'd0);
        chk("bp_hold_power", 64'(beam_power), 64'({4{8'd4}}));

        do_reset();
        chk("reset_clears_flags", 64'({drop, underflow}), 64'd0);

        // Tag wrap with rbg_max=2
        rbg_max = 8'd2;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] exp_tag;
            exp_tag = (k == 0 || k == 3 || k == 4) ? 8'd0 : ((k == 2) ? 8'd2 : 8'd1);
            send({8{8'(k)}}, 1'b0, (k == 0) || (k == 4));
            tick(); tick();
            pop();
            chk("wrap_rd_valid", 64'(rd_valid), 64'd1);
            chk("wrap_tag", 64'(rbg_num), 64'(exp_tag));
        end

        // Reset mid-operation: 2 stored, 1 in flight
        rbg_max = 8'd255;
        pop();
        chk("mid_underflow_set", 64'(underflow), 64'd1);
        send({8{8'd11}}, 1'b0, 1'b0);
        send({8{8'd12}}, 1'b0, 1'b0);
        tick(); tick();
        chk("mid_count_before", 64'(count), 64'd2);
        send({8{8'd13}}, 1'b0, 1'b0);
        do_reset();
        chk("mid_count", 64'(count), 64'd0);
        chk("mid_empty", 64'(empty), 64'd1);
        chk("mid_flags", 64'({drop, underflow}), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_late_write", 64'(count), 64'd0);
            chk("mid_no_rank_valid", 64'(rank_valid), 64'd0);
            tick();
        end
        send({8{8'd14}}, 1'b0, 1'b0);
        tick(); tick();
        pop();
        chk("mid_next_rd_valid", 64'(rd_valid), 64'd1);
        chk("mid_next_tag", 64'(rbg_num), 64'd0);
        chk("mid_next_power", 64'(beam_power), 64'({4{8'd14}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/beam_topk_sort.md
Name: beam_topk_sort

Overview:
- Parametrised successor to the PUSCH beam-power sorter.
- Takes one vector of COL beam powers per RBG and ranks all columns with a fully parallel pairwise compare. The sort direction (descending or ascending) is selectable per vector.
- Writes the top TOPK beam indices and their powers, tagged with an RBG number, into a RBG_DEPTH-entry FIFO. The downstream dimension-reduction stage drains that FIFO with a simple read handshake.

Parameters:
- IW, 32, beam power width (unsigned)
- COL, 64, beams per vector (power of 2, 2..128)
- TOPK, 16, beams kept per RBG (1..COL)
- RBG_DEPTH, 16, FIFO entries (power of 2, >=2)
- IDXW, $clog2(COL) (localparam), index/rank width

Ports:
- i_clk  input  1  clock; all logic on rising edge
- i_reset_n  input  1  synchronous reset, active-low
- i_data  input  [COL-1:0][IW-1:0]  beam powers
- i_valid  input  1  vector valid
- i_mode  input  1  0 = descending (largest first), 1 = ascending; sampled with the vector
- i_sop  input  1  first RBG of slot; sampled with the vector
- i_rbg_max  input  8  last RBG number before wrap
- o_in_ready  output  1  vector accepted when i_valid & o_in_ready
- o_rank  output  [COL-1:0][IW-1:0→IDXW-1:0]  rank of each column of the last accepted vector (0 = highest priority)
- o_rank_valid  output  1  one-cycle strobe, o_rank updated
- i_rd_en  input  1  pop request
- o_rd_valid  output  1  read data valid (one cycle)
- o_beam_index  output  [TOPK-1:0][IDXW-1:0]  sorted indices, entry 0 = highest priority
- o_beam_power  output  [TOPK-1:0][IW-1:0]  matching powers
- o_rbg_num  output  8  RBG tag of popped entry
- o_count  output  $clog2(RBG_DEPTH)+1  stored entries
- o_empty, o_full  output  1  FIFO status
- o_drop  output  1  sticky: i_valid seen while o_in_ready=0
- o_underflow  output  1  sticky: i_rd_en seen while o_empty=1

Behaviour:
- Reset (i_reset_n=0 at a clock edge) returns every output to 0, except o_empty=1 and o_in_ready=1 once reset is released. Reset clears the FIFO pointers, the in-flight pipeline, the RBG counter and both sticky flags. Reset mid-operation discards in-flight and stored entries without any partial write.
- Ranking, stage 1 (cycle T+1 for a vector accepted at T): register the vector, mode and tag.
  - Descending: rank[i] = count of j with d[j]>d[i], plus count of j<i with d[j]==d[i].
  - Ascending: the same with < in place of >.
  - Ties always go to the lower index, so the ranks form a permutation of 0..COL-1.
- Stage 2 (T+2): register o_rank and pulse o_rank_valid. Scatter: for each i with rank[i]<TOPK, set slot[rank[i]] = {i, d[i]}.
- Stage 3 (T+3): write the slots and the tag into the FIFO. The entry is poppable from the T+4 edge.
- RBG tag:
  - An accepted vector with i_sop=1 gets tag 0.
  - Otherwise the tag is the previous tag + 1, wrapping to 0 after i_rbg_max.
  - The first vector after reset gets tag 0.
- o_in_ready = (o_count + in_flight) < RBG_DEPTH, computed from registered state only. A same-cycle pop does not raise ready.
- When i_valid=1 and o_in_ready=0, the vector is discarded and o_drop is set.
- Read:
  - i_rd_en with o_empty=0 pops the head.
  - o_rd_valid=1 on the next cycle, with data, tag and o_count already updated.
  - i_rd_en with o_empty=1 is ignored, sets o_underflow, and o_rd_valid stays 0.
  - Outside o_rd_valid, the data outputs hold their last values.
- A simultaneous stage-3 write and pop leaves o_count unchanged and both proceed. Pointers wrap modulo RBG_DEPTH.
- Throughput is one vector per cycle while ready; there are no bubbles between back-to-back vectors.

Test Plan (COL=8, TOPK=4, RBG_DEPTH=4):
- Descending order: accept d=[5,9,1,9,0,7,3,2], mode 0, then pop.
  - Index {1,3,5,0}, power {9,9,7,5}, tag 0.
  - o_rank=[3,0,6,1,7,2,4,5].
  - o_rank_valid at T+2; entry poppable at T+4.
- Ascending order: same d with mode 1 → index {4,2,7,6}, power {0,1,2,3}.
- All-equal vector: d=all 0x55 → index {0,1,2,3}, o_rank=[0..7].
- Back-pressure: 5 back-to-back vectors with no reads.
  - o_in_ready falls after the 4th is accepted, the 5th is dropped and o_drop=1, o_full=1 at T+4.
  - Then pop 4 times: FIFO order holds, o_empty=1.
  - A 5th pop gives o_underflow=1 and o_rd_valid=0.
- Tag wrap: i_rbg_max=2 with six vectors, i_sop on the 1st and 5th → tags 0,1,2,0,0,1.
- Reset mid-operation: 2 stored entries plus 1 in flight, then pulse i_reset_n low for 1 cycle.
  - o_count=0, o_empty=1, flags 0, no late write appears.
  - The next vector gets tag 0.
